// File: rtl/traffic_pkg.sv
// Shared types and helpers for the N-approach traffic controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2,
    PH_FLASH  = 2'd3
  } phase_e;

  // Lengths are widened to this before comparison; CNT_W must not exceed it.
  localparam int LEN_W = 64;

  // A zero-length phase still occupies one cycle.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    return (len == '0) ? LEN_W'(1) : len;
  endfunction

endpackage

// File: rtl/traffic_rr_pick.sv
// Circular next-approach selector: first requesting index after active_dir,
// active_dir itself last, plain increment when nobody is waiting.
module traffic_rr_pick #(
  parameter  int NUM_DIR = 2,
  localparam int DIR_W   = $clog2(NUM_DIR)
) (
  input  logic [NUM_DIR-1:0] car_req,
  input  logic [DIR_W-1:0]   active_dir,
  output logic [DIR_W-1:0]   next_dir
);

  always_comb begin
    logic             found;
    int               idx;
    logic [DIR_W-1:0] idx_d;
    found    = 1'b0;
    idx      = 0;
    idx_d    = '0;
    next_dir = (active_dir == DIR_W'(NUM_DIR-1)) ? '0 : active_dir + DIR_W'(1);
    for (int i = 1; i <= NUM_DIR; i++) begin
      idx = int'(active_dir) + i;
      if (idx >= NUM_DIR) idx = idx - NUM_DIR;
      idx_d = DIR_W'(idx);
      if (!found && car_req[idx_d]) begin
        found    = 1'b1;
        next_dir = idx_d;
      end
    end
  end

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// N-approach traffic-light controller: GREEN -> YELLOW -> ALLRED per approach,
// skipping idle approaches. Optional flash mode under `TRAFFIC_FLASH_EN.
module traffic_intersection_ctrl
  import traffic_pkg::*;
#(
  parameter  int NUM_DIR = 2,
  parameter  int CNT_W   = 32,
  localparam int DIR_W   = $clog2(NUM_DIR)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [CNT_W-1:0]   green_len,
  input  logic [CNT_W-1:0]   yellow_len,
  input  logic [CNT_W-1:0]   allred_len,
  input  logic [NUM_DIR-1:0] car_req,
`ifdef TRAFFIC_FLASH_EN
  input  logic               flash,
`endif
  output logic [CNT_W-1:0]   q,
  output logic [DIR_W-1:0]   active_dir,
  output logic [1:0]         phase,
  output logic [NUM_DIR-1:0] greenlt,
  output logic [NUM_DIR-1:0] yellowlt,
  output logic [NUM_DIR-1:0] redlt
);

  phase_e             ph_q, ph_n;
  logic [CNT_W-1:0]   q_n;
  logic [DIR_W-1:0]   dir_n, next_dir;
  logic [CNT_W-1:0]   cur_len;
  logic               done;
  logic               blink;
  logic [NUM_DIR-1:0] sel;

  traffic_rr_pick #(.NUM_DIR(NUM_DIR)) u_pick (
    .car_req    (car_req),
    .active_dir (active_dir),
    .next_dir   (next_dir)
  );

  // Live length inputs: shrinking mid-phase ends the phase instead of wrapping q.
  always_comb begin
    cur_len = allred_len;
    case (ph_q)
      PH_GREEN:  cur_len = green_len;
      PH_YELLOW: cur_len = yellow_len;
      PH_FLASH:  cur_len = yellow_len;
      default:   cur_len = allred_len;
    endcase
    done = LEN_W'(q) >= (eff_len(LEN_W'(cur_len)) - LEN_W'(1));
  end

`ifdef TRAFFIC_FLASH_EN
  logic blink_n;
`endif

  always_comb begin
    ph_n  = ph_q;
    q_n   = q + CNT_W'(1);
    dir_n = active_dir;
`ifdef TRAFFIC_FLASH_EN
    blink_n = blink;
`endif
    case (ph_q)
      PH_GREEN: if (done) begin
        ph_n = PH_YELLOW;
        q_n  = '0;
      end
      PH_YELLOW: if (done) begin
        ph_n = PH_ALLRED;
        q_n  = '0;
      end
      PH_ALLRED: if (done) begin
        ph_n  = PH_GREEN;
        q_n   = '0;
        dir_n = next_dir;
      end
      PH_FLASH: begin
`ifdef TRAFFIC_FLASH_EN
        if (done) begin
          blink_n = ~blink;
          q_n     = '0;
        end
`else
        ph_n = PH_ALLRED;
        q_n  = '0;
`endif
      end
      default: begin
        ph_n = PH_ALLRED;
        q_n  = '0;
      end
    endcase
`ifdef TRAFFIC_FLASH_EN
    // Flash request overrides the normal sequence; leaving flash always clears through ALLRED.
    if (flash && ph_q != PH_FLASH) begin
      ph_n    = PH_FLASH;
      q_n     = '0;
      blink_n = 1'b1;
    end else if (!flash && ph_q == PH_FLASH) begin
      ph_n    = PH_ALLRED;
      q_n     = '0;
      blink_n = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph_q       <= PH_ALLRED;
      q          <= '0;
      active_dir <= DIR_W'(NUM_DIR-1);
    end else begin
      ph_q       <= ph_n;
      q          <= q_n;
      active_dir <= dir_n;
    end
  end

`ifdef TRAFFIC_FLASH_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) blink <= 1'b0;
    else       blink <= blink_n;
  end
`else
  assign blink = 1'b0;
`endif

  assign phase = ph_q;
  assign sel   = NUM_DIR'(1) << active_dir;

  always_comb begin
    greenlt  = '0;
    yellowlt = '0;
    redlt    = '1;
    case (ph_q)
      PH_GREEN: begin
        greenlt = sel;
        redlt   = ~sel;
      end
      PH_YELLOW: begin
        yellowlt = sel;
        redlt    = ~sel;
      end
      PH_FLASH: begin
        yellowlt = {NUM_DIR{blink}};
        redlt    = '0;
      end
      default: ;
    endcase
  end

  // Safety: one lit approach at most outside flash; GREEN only entered from ALLRED.
  a_one_lit: assert property (@(posedge clk) disable iff (reset)
    (ph_q != PH_FLASH) |-> $onehot0(~redlt));
  a_green_entry: assert property (@(posedge clk) disable iff (reset)
    (ph_q == PH_GREEN && $past(ph_q) != PH_GREEN) |-> ($past(ph_q) == PH_ALLRED));

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Scoreboard bench for traffic_intersection_ctrl: expectations are queued with
// the cycle they apply to, and a negedge monitor compares them.
module tb_traffic_intersection_ctrl;
  import traffic_pkg::*;

  localparam int ND = 4;
  localparam int CW = 16;
  localparam int DW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CW-1:0] green_len, yellow_len, allred_len;
  logic [ND-1:0] car_req;
`ifdef TRAFFIC_FLASH_EN
  logic          flash = 1'b0;
`endif
  logic [CW-1:0] q;
  logic [DW-1:0] active_dir;
  logic [1:0]    phase;
  logic [ND-1:0] greenlt, yellowlt, redlt;

  traffic_intersection_ctrl #(.NUM_DIR(ND), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .green_len  (green_len),
    .yellow_len (yellow_len),
    .allred_len (allred_len),
    .car_req    (car_req),
`ifdef TRAFFIC_FLASH_EN
    .flash      (flash),
`endif
    .q          (q),
    .active_dir (active_dir),
    .phase      (phase),
    .greenlt    (greenlt),
    .yellowlt   (yellowlt),
    .redlt      (redlt)
  );

  always #5 clk = ~clk;

  // Cycle index since the last reset release (0 = first cycle out of reset).
  int cyc = 0;
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  typedef struct {
    int            c;
    logic [1:0]    ph;
    logic [DW-1:0] dir;
    logic [CW-1:0] qv;
    logic [ND-1:0] g, y, r;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  bit   chk_end = 1'b0;
  bit   end_done = 1'b0;

  task automatic push(input int c, input phase_e ph, input int dir, input int qv, input bit blk);
    exp_t e;
    logic [ND-1:0] s;
    s     = ND'(1) << dir;
    e.c   = c;
    e.ph  = ph;
    e.dir = DW'(dir);
    e.qv  = CW'(qv);
    e.g   = '0;
    e.y   = '0;
    e.r   = '1;
    case (ph)
      PH_GREEN:  begin e.g = s; e.r = ~s; end
      PH_YELLOW: begin e.y = s; e.r = ~s; end
      PH_FLASH:  begin e.y = {ND{blk}}; e.r = '0; end
      default: ;
    endcase
    sb.push_back(e);
  endtask

  task automatic wait_k(input int k);
    int n;
    n = 0;
    while (cyc < k && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial forever begin
    @(negedge clk);
    while (sb.size() > 0 && sb[0].c <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (e.c != cyc || phase !== e.ph || active_dir !== e.dir || q !== e.qv ||
          greenlt !== e.g || yellowlt !== e.y || redlt !== e.r) begin
        failures++;
        $display("FAIL state@cyc%0d (now cyc%0d): got ph=%0d dir=%0d q=%0d g=%b y=%b r=%b, want ph=%0d dir=%0d q=%0d g=%b y=%b r=%b",
                 e.c, cyc, phase, active_dir, q, greenlt, yellowlt, redlt,
                 e.ph, e.dir, e.qv, e.g, e.y, e.r);
      end
    end
    if (chk_end && !end_done) begin
      checks++;
      if (sb.size() != 0) begin
        failures++;
        $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      end
      end_done = 1'b1;
    end
  end

  initial begin
    green_len  = CW'(4);
    yellow_len = CW'(2);
    allred_len = CW'(1);
    car_req    = 4'b0011;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Rotation 0 <-> 1, then demand skip, no demand, zero / shrinking lengths.
    push(0,  PH_ALLRED, 3, 0, 0);
    push(1,  PH_GREEN,  0, 0, 0);
    push(4,  PH_GREEN,  0, 3, 0);
    push(5,  PH_YELLOW, 0, 0, 0);
    push(6,  PH_YELLOW, 0, 1, 0);
    push(7,  PH_ALLRED, 0, 0, 0);
    push(8,  PH_GREEN,  1, 0, 0);
    push(11, PH_GREEN,  1, 3, 0);
    push(12, PH_YELLOW, 1, 0, 0);
    push(14, PH_ALLRED, 1, 0, 0);
    push(15, PH_GREEN,  0, 0, 0);
    push(21, PH_ALLRED, 0, 0, 0);
    push(22, PH_GREEN,  3, 0, 0);
    push(26, PH_YELLOW, 3, 0, 0);
    push(28, PH_ALLRED, 3, 0, 0);
    push(29, PH_GREEN,  0, 0, 0);
    push(35, PH_ALLRED, 0, 0, 0);
    push(36, PH_GREEN,  1, 0, 0);
    push(42, PH_ALLRED, 1, 0, 0);
    push(43, PH_GREEN,  2, 0, 0);
    push(44, PH_YELLOW, 2, 0, 0);
    push(47, PH_GREEN,  3, 0, 0);
    push(48, PH_YELLOW, 3, 0, 0);
    push(51, PH_GREEN,  0, 0, 0);
    push(56, PH_GREEN,  0, 5, 0);
    push(57, PH_YELLOW, 0, 0, 0);
    push(62, PH_GREEN,  1, 2, 0);

    wait_k(15); car_req = 4'b1001;
    wait_k(29); car_req = 4'b0010;
    wait_k(36); car_req = 4'b0000;
    wait_k(43); green_len = CW'(0);
    wait_k(48); green_len = CW'(10);
    wait_k(56); green_len = CW'(2);
    wait_k(57); green_len = CW'(6);
    wait_k(63);
    // Mid-GREEN (q=3) reset must show reset state before any clock edge.
    push(63, PH_ALLRED, 3, 0, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

`ifdef TRAFFIC_FLASH_EN
    green_len  = CW'(4);
    yellow_len = CW'(3);
    allred_len = CW'(1);
    car_req    = 4'b0011;
    #1 reset = 1'b0;
    push(0,  PH_ALLRED, 3, 0, 0);
    push(1,  PH_GREEN,  0, 0, 0);
    push(3,  PH_FLASH,  0, 0, 1);
    push(5,  PH_FLASH,  0, 2, 1);
    push(6,  PH_FLASH,  0, 0, 0);
    push(8,  PH_FLASH,  0, 2, 0);
    push(9,  PH_FLASH,  0, 0, 1);
    push(10, PH_ALLRED, 0, 0, 0);
    push(11, PH_GREEN,  1, 0, 0);
    wait_k(2); flash = 1'b1;
    wait_k(9); flash = 1'b0;
    wait_k(12);
`endif

    chk_end = 1'b1;
    for (int i = 0; i < 5 && !end_done; i++) @(negedge clk);
    #1;
    if (!end_done) begin
      failures++;
      $display("FAIL monitor_timeout: got no drain check, want one");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
